blake2_cmd_tx: RTL and testbench
================================

// Module: blake2_cmd_tx
// PURPOSE
//  Host-side transmitter for the BLAKE2 byte-serial command interface (valid/cmd[1:0]/data[7:0]).
//  Converts one hash job (kk, nn, ll plus a key-then-message byte source) into the exact command
//  stream the core's I/O front end consumes: config bytes, then zero-padded 64-byte blocks with
//  START/DATA/LAST tagging. Sits in the bench/host wrapper (or FPGA harness), driving the core's inputs.
// PARAMETERS
//  BLOCK_W  6  log2(bytes per block); 6 = 64-byte BLAKE2s block, must match core data index width
// PORTS
//  clk         in   1   clock
//  nreset      in   1   asynchronous active-low reset
//  start_i     in   1   job request pulse; kk_i/nn_i/ll_i sampled when start_i & ~busy_o
//  kk_i        in   6   key length in bytes (0 = unkeyed)
//  nn_i        in   6   digest length in bytes
//  ll_i        in   64  message length in bytes
//  busy_o      out  1   job in progress
//  done_o      out  1   1-cycle pulse after last byte of last block issued
//  src_valid_i in   1   source byte available (key bytes first, then message bytes)
//  src_data_i  in   8   source byte
//  src_ready_o out  1   source byte consumed this cycle when src_valid_i & src_ready_o
//  ready_i     in   1   core ready (core's ready_v_o); gates start of each block
//  valid_o     out  1   command byte valid
//  cmd_o       out  2   0=CONF 1=START 2=DATA 3=LAST
//  data_o      out  8   command payload byte
// BEHAVIOUR
//  Async reset: state IDLE; busy_o, done_o, valid_o, src_ready_o = 0; cmd_o = 0; data_o = 0; counters 0.
//  All outputs registered; one command byte max per cycle; valid_o low = idle cycle, core ignores it.
//  FSM: IDLE -> CONF -> WAIT_RDY -> BLOCK -> (WAIT_RDY | DONE) -> IDLE.
//   IDLE: start_i latches kk,nn,ll; key_rem=kk, msg_rem=ll; key_blk=(kk!=0); first=1; -> CONF.
//     start_i while busy_o=1 ignored.
//   CONF: 10 back-to-back bytes, cmd=0: kk, nn, ll[7:0], ll[15:8] .. ll[63:56] (LSB first). -> WAIT_RDY.
//   WAIT_RDY: hold valid_o=0 until ready_i=1, then -> BLOCK with byte idx=0. ready_i checked only here.
//   BLOCK: 2^BLOCK_W byte slots, idx 0..63. Per slot:
//     key block: byte = src byte while key_rem>0 (key_rem--), else 0x00 pad (no source pop).
//     msg block: byte = src byte while msg_rem>0 (msg_rem--), else 0x00 pad.
//     Source byte needed and src_valid_i=0 -> stall: valid_o=0, idx held, no cmd emitted.
//     src_ready_o asserted only in slots consuming a source byte; no pop in pad slots.
//     last block = (key block & ll==0) | (msg block & msg_rem<=remaining slots incl. current).
//     cmd for idx 0: START if first block, else LAST if last block, else DATA.
//     cmd for idx 1..63: LAST if last block, else DATA.
//     (single-block job => idx0 START, idx1..63 LAST: core flags first & last.)
//     End of slot 63: first=0; last block -> DONE, else key block finished -> msg phase; -> WAIT_RDY.
//   DONE: done_o=1 for one cycle, busy_o=0 next cycle -> IDLE.
//  Block count = key_blk + max(ceil(ll/64), key_blk?0:1); kk=0 & ll=0 -> one all-zero block.
//  ll handled by 64-bit down-counter; no multiply/divide; ll up to 2^64-1 legal.
//  kk/nn not range-checked; forwarded verbatim.
//  nreset low mid-job: immediate abort, valid_o=0 same cycle (async); core must see a fresh CONF next job.
// TESTING
//  kk=0,nn=32,ll=0x0102030405060708 -> 10 CONF bytes 00,20,08,07,06,05,04,03,02,01, cmd=0 each.
//  kk=0,ll=0, ready_i=1 -> CONF, then 64 bytes 0x00: idx0 cmd=1, idx1..63 cmd=3; done_o one cycle after.
//  kk=0,ll=65, src bytes 0..64 -> blk0: idx0 START, 1..63 DATA, data 0..63; blk1: byte 64 then 63x 0x00, all LAST.
//  kk=32,ll=3 -> key blk (32 key + 32 pad, START/DATA) then msg blk (3 bytes + 61 pad, all LAST); 35 pops total.
//  src_valid_i low 5 cycles at idx 10; ready_i low 7 cycles between blocks -> valid_o gaps, no dup/skip bytes.
//  nreset asserted at idx 20 of block 1 -> outputs 0 at once; new start_i then replays full CONF + blocks.

Source files
------------

// File: rtl/blake2_cmd_tx.sv
// Purpose: host-side transmitter turning one BLAKE2 job (kk, nn, ll + key/message source) into the core's command stream.
// Latency: first CONF byte appears two cycles after an accepted start_i; every output is registered.
// Backpressure: ready_i gates the start of each 64-byte block; an empty source stalls the current slot.
module blake2_cmd_tx #(
  parameter int BLOCK_W = 6
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        src_valid_i,
  input  logic [7:0]  src_data_i,
  output logic        src_ready_o,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o
);

  localparam int NSLOT = 1 << BLOCK_W;

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_WAIT_RDY,
    S_BLOCK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [79:0]          conf_sh_q, conf_sh_d;   // CONF bytes, shifted out LSB first
  logic [3:0]           conf_cnt_q, conf_cnt_d;
  logic [BLOCK_W-1:0]   idx_q, idx_d;
  logic [5:0]           key_rem_q, key_rem_d;
  logic [63:0]          msg_rem_q, msg_rem_d;
  logic                 key_blk_q, key_blk_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 ll_zero_q, ll_zero_d;
  logic                 valid_q, valid_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [7:0]           data_q, data_d;
  logic                 src_rdy_q, src_rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 need;
  logic                 need_d;

  // Next-state logic: job sequencing, slot fill/pad decisions and the registered output values
  always_comb begin
    state_d    = state_q;
    conf_sh_d  = conf_sh_q;
    conf_cnt_d = conf_cnt_q;
    idx_d      = idx_q;
    key_rem_d  = key_rem_q;
    msg_rem_d  = msg_rem_q;
    key_blk_d  = key_blk_q;
    first_d    = first_q;
    last_d     = last_q;
    ll_zero_d  = ll_zero_q;
    valid_d    = 1'b0;
    cmd_d      = cmd_q;
    data_d     = data_q;
    done_d     = 1'b0;
    need       = key_blk_q ? (key_rem_q != 6'd0) : (msg_rem_q != 64'd0);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          conf_sh_d  = {ll_i, 2'b00, nn_i, 2'b00, kk_i};
          conf_cnt_d = 4'd0;
          key_rem_d  = kk_i;
          msg_rem_d  = ll_i;
          key_blk_d  = (kk_i != 6'd0);
          first_d    = 1'b1;
          ll_zero_d  = (ll_i == 64'd0);
          state_d    = S_CONF;
        end
      end
      S_CONF: begin
        valid_d    = 1'b1;
        cmd_d      = CMD_CONF;
        data_d     = conf_sh_q[7:0];
        conf_sh_d  = conf_sh_q >> 8;
        conf_cnt_d = conf_cnt_q + 4'd1;
        if (conf_cnt_q == 4'd9) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (ready_i) begin
          idx_d   = '0;
          // The whole block decides "last" up front: the remaining message bytes either
          // fit in this block or they do not, and that cannot change within the block.
          last_d  = key_blk_q ? ll_zero_q : (msg_rem_q <= 64'(NSLOT));
          state_d = S_BLOCK;
        end
      end
      S_BLOCK: begin
        if (!need || src_valid_i) begin
          valid_d = 1'b1;
          data_d  = need ? src_data_i : 8'h00;
          if (idx_q == '0 && first_q) cmd_d = CMD_START;
          else if (last_q)            cmd_d = CMD_LAST;
          else                        cmd_d = CMD_DATA;
          if (need) begin
            if (key_blk_q) key_rem_d = key_rem_q - 6'd1;
            else           msg_rem_d = msg_rem_q - 64'd1;
          end
          if (idx_q == BLOCK_W'(NSLOT - 1)) begin
            first_d = 1'b0;
            if (last_q) begin
              state_d = S_DONE;
            end else begin
              key_blk_d = 1'b0;
              state_d   = S_WAIT_RDY;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    need_d    = key_blk_d ? (key_rem_d != 6'd0) : (msg_rem_d != 64'd0);
    src_rdy_d = (state_d == S_BLOCK) && need_d;
  end

  // State and output registers; reset aborts any job and silences the command bus at once
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      conf_sh_q  <= '0;
      conf_cnt_q <= '0;
      idx_q      <= '0;
      key_rem_q  <= '0;
      msg_rem_q  <= '0;
      key_blk_q  <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      ll_zero_q  <= 1'b0;
      valid_q    <= 1'b0;
      cmd_q      <= '0;
      data_q     <= '0;
      src_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conf_sh_q  <= conf_sh_d;
      conf_cnt_q <= conf_cnt_d;
      idx_q      <= idx_d;
      key_rem_q  <= key_rem_d;
      msg_rem_q  <= msg_rem_d;
      key_blk_q  <= key_blk_d;
      first_q    <= first_d;
      last_q     <= last_d;
      ll_zero_q  <= ll_zero_d;
      valid_q    <= valid_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      src_rdy_q  <= src_rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign src_ready_o = src_rdy_q;
  assign valid_o     = valid_q;
  assign cmd_o       = cmd_q;
  assign data_o      = data_q;

endmodule

// File: tb/tb_blake2_cmd_tx.sv
module tb_blake2_cmd_tx;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  kk_i = '0;
  logic [5:0]  nn_i = '0;
  logic [63:0] ll_i = '0;
  logic        busy_o, done_o;
  logic        src_valid_i = 1'b0;
  logic [7:0]  src_data_i = '0;
  logic        src_ready_o;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [1:0]  cmd_o;
  logic [7:0]  data_o;

  always #5 clk = ~clk;

  blake2_cmd_tx #(.BLOCK_W(6)) dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .busy_o(busy_o), .done_o(done_o), .src_valid_i(src_valid_i), .src_data_i(src_data_i),
    .src_ready_o(src_ready_o), .ready_i(ready_i), .valid_o(valid_o), .cmd_o(cmd_o), .data_o(data_o)
  );

  int compared = 0;
  int mismatched = 0;

  logic [9:0] out_q[$];   // observed {cmd, data}
  logic [9:0] exp_q[$];   // expected {cmd, data}
  logic [7:0] src_q[$];   // bytes still to be offered by the source
  int pops, done_cnt, done_at;
  int ready_mode = 0;     // 0 low, 1 high, 2 random with 8-cycle gaps
  int rdy_low = 0;
  bit src_rand = 1'b1;
  int stall_at = -1;
  int stall_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source/ready driver and output monitor, all away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (valid_o) out_q.push_back({cmd_o, data_o});
        if (done_o) begin
          done_cnt++;
          done_at = out_q.size();
        end
      end
      case (ready_mode)
        0: ready_i = 1'b0;
        1: ready_i = 1'b1;
        default: begin
          if (rdy_low > 0) begin
            ready_i = 1'b0;
            rdy_low--;
          end else if ($urandom_range(0, 15) == 0) begin
            ready_i = 1'b0;
            rdy_low = 7;
          end else begin
            ready_i = 1'b1;
          end
        end
      endcase
      if (src_q.size() > 0 && nreset) begin
        if (pops == stall_at && stall_left > 0) begin
          src_valid_i = 1'b0;
          stall_left--;
        end else begin
          src_valid_i = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        src_data_i = src_q[0];
      end else begin
        src_valid_i = 1'b0;
        src_data_i = 8'($urandom);
      end
      #1;
      if (src_valid_i && src_ready_o) begin
        void'(src_q.pop_front());
        pops++;
      end
    end
  end

  // Reference: CONF bytes, then key block (if any) and message blocks, zero padded
  task automatic prep(input int kk, input int nn, input int ll);
    logic [7:0] kb[$];
    logic [7:0] mb[$];
    logic [7:0] flat[$];
    logic [63:0] l64;
    logic [7:0] b;
    logic [1:0] c;
    int nmb, nb, blk, slot;
    out_q.delete(); exp_q.delete(); src_q.delete();
    pops = 0; done_cnt = 0; done_at = -1;
    stall_at = 10; stall_left = 5;
    for (int i = 0; i < kk; i++) begin b = 8'($urandom); kb.push_back(b); src_q.push_back(b); end
    for (int i = 0; i < ll; i++) begin b = 8'($urandom); mb.push_back(b); src_q.push_back(b); end
    l64 = 64'(ll);
    exp_q.push_back({2'd0, 8'(kk)});
    exp_q.push_back({2'd0, 8'(nn)});
    for (int i = 0; i < 8; i++) exp_q.push_back({2'd0, 8'(l64 >> (8 * i))});
    if (kk > 0) begin
      flat = kb;
      while (flat.size() < 64) flat.push_back(8'h00);
    end
    nmb = (ll + 63) / 64;
    if (kk == 0 && nmb == 0) nmb = 1;
    nb = ((kk > 0) ? 1 : 0) + nmb;
    for (int j = 0; j < nmb * 64; j++) flat.push_back((j < ll) ? mb[j] : 8'h00);
    for (int j = 0; j < nb * 64; j++) begin
      blk = j / 64;
      slot = j % 64;
      c = (blk == 0 && slot == 0) ? 2'd1 : (blk == nb - 1) ? 2'd3 : 2'd2;
      exp_q.push_back({c, flat[j]});
    end
  endtask

  // Start pulse, followed by a stray start while busy that must be ignored
  task automatic kick(input int kk, input int nn, input logic [63:0] ll);
    @(negedge clk); #2;
    kk_i = 6'(kk); nn_i = 6'(nn); ll_i = ll; start_i = 1'b1;
    @(negedge clk); #2;
    start_i = 1'b0; kk_i = ~kk_i; nn_i = ~nn_i; ll_i = ll_i + 64'd7;
    repeat (3) @(negedge clk);
    #2 start_i = 1'b1;
    @(negedge clk); #2 start_i = 1'b0;
  endtask

  task automatic finish_job(input string tag, input int kk, input int ll);
    int n = 0;
    int ok;
    while (done_cnt == 0 && n < 8000) begin
      @(negedge clk); #2;
      n++;
    end
    check({tag, " done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    check({tag, " len"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] o;
      o = (i < out_q.size()) ? out_q[i] : 10'bx;
      ok = mismatched;
      check($sformatf("%s byte%0d", tag, i), 64'(o), 64'(exp_q[i]));
      if (mismatched != ok) break;
    end
    check({tag, " pops"}, 64'(pops), 64'(kk + ll));
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " done_after_last"}, 64'(done_at), 64'(exp_q.size()));
    check({tag, " busy_end"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int n;
    int kk, ll;
    // Reset state
    #2 nreset = 1'b0;
    #1;
    check("rst valid", 64'(valid_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst src_ready", 64'(src_ready_o), 64'd0);
    check("rst cmd", 64'(cmd_o), 64'd0);
    check("rst data", 64'(data_o), 64'd0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // CONF byte order with a large ll; core held not-ready
    ready_mode = 0;
    out_q.delete(); exp_q.delete(); src_q.delete(); pops = 0; done_cnt = 0;
    begin
      logic [7:0] cb[10];
      cb = '{8'h00, 8'h20, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      for (int i = 0; i < 10; i++) exp_q.push_back({2'd0, cb[i]});
    end
    kick(0, 32, 64'h0102030405060708);
    n = 0;
    while (out_q.size() < 10 && n < 100) begin @(negedge clk); #2; n++; end
    repeat (4) @(negedge clk);
    #2;
    check("conf len", 64'(out_q.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("conf byte%0d", i), 64'((i < out_q.size()) ? out_q[i] : 10'bx), 64'(exp_q[i]));
    check("conf wait busy", 64'(busy_o), 64'd1);
    check("conf wait valid", 64'(valid_o), 64'd0);
    nreset = 1'b0;
    #1;
    check("conf abort busy", 64'(busy_o), 64'd0);
    @(negedge clk); #2 nreset = 1'b1;

    // Unkeyed empty message: single all-zero block
    ready_mode = 1;
    prep(0, 32, 0);
    kick(0, 32, 64'd0);
    finish_job("k0_l0", 0, 0);

    // Two message blocks with stalls and ready gaps
    ready_mode = 2;
    prep(0, 16, 65);
    kick(0, 16, 64'd65);
    finish_job("k0_l65", 0, 65);

    // Key block then short message block
    prep(32, 32, 3);
    kick(32, 32, 64'd3);
    finish_job("k32_l3", 32, 3);

    // Abort mid-stream at slot 20 of the second block
    ready_mode = 1;
    src_rand = 1'b0;
    prep(0, 7, 200);
    stall_left = 0;
    kick(0, 7, 64'd200);
    n = 0;
    while (out_q.size() < 10 + 64 + 20 && n < 2000) begin @(negedge clk); #2; n++; end
    check("abort pre valid", 64'(valid_o), 64'd1);
    nreset = 1'b0;
    #1;
    check("abort valid", 64'(valid_o), 64'd0);
    check("abort busy", 64'(busy_o), 64'd0);
    check("abort src_ready", 64'(src_ready_o), 64'd0);
    check("abort cmd", 64'(cmd_o), 64'd0);
    check("abort data", 64'(data_o), 64'd0);
    repeat (2) @(negedge clk);
    #2 nreset = 1'b1;
    src_rand = 1'b1;

    // Fresh job after abort replays CONF and all blocks
    ready_mode = 2;
    prep(5, 20, 130);
    kick(5, 20, 64'd130);
    finish_job("after_abort", 5, 130);

    // Random jobs
    for (int r = 0; r < 4; r++) begin
      kk = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 63));
      ll = int'($urandom_range(0, 200));
      prep(kk, r + 1, ll);
      kick(kk, r + 1, 64'(ll));
      finish_job($sformatf("rand%0d", r), kk, ll);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
